// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit to every frame (8E1 instead of 8N1).
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEF = 434;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_REQ_ENC    = 3'd1;
  localparam logic [2:0] ST_CAPT_ENC   = 3'd2;
  localparam logic [2:0] ST_START_ENC  = 3'd3;
  localparam logic [2:0] ST_DATA_ENC   = 3'd4;
  localparam logic [2:0] ST_STOP_ENC   = 3'd5;
  localparam logic [2:0] ST_PARITY_ENC = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_REQ    = ST_REQ_ENC,
    S_CAPT   = ST_CAPT_ENC,
    S_START  = ST_START_ENC,
    S_DATA   = ST_DATA_ENC,
`ifdef UART_TX_PARITY_EN
    S_PARITY = ST_PARITY_ENC,
`endif
    S_STOP   = ST_STOP_ENC
  } uart_state_t;

  // Bit times per frame, including start, optional parity and stop.
  function automatic int uart_frame_bits(input int d_width);
`ifdef UART_TX_PARITY_EN
    return d_width + 3;
`else
    return d_width + 2;
`endif
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, wraps at bit end, clears on request.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_WIDTH    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 bit_end
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CNT_WIDTH'(CLKS_PER_BIT - 1));
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(1);
    if (clr || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Drains the byte FIFO with single-cycle rd pulses and sends each byte as a UART frame.
// UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int CNT_WIDTH    = 9,
  parameter int D_WIDTH      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_data,
  input  logic               fifo_err_unf,
  output logic               fifo_rd,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

  localparam int IDX_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

  uart_state_t          state_q, state_d;
  logic [D_WIDTH-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 fifo_rd_q, fifo_rd_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 cnt_clr;
  logic                 bit_end;
  logic [CNT_WIDTH-1:0] cnt;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .cnt     (cnt),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE:  if (en && !fifo_empty) state_d = S_REQ;
      S_REQ:   state_d = S_CAPT;
      S_CAPT: begin
        // An underflowed read carries no valid byte; drop it without touching the line.
        if (fifo_err_unf) begin
          state_d = S_IDLE;
        end else begin
          shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_data;
`endif
          state_d = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(D_WIDTH - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cnt_clr   = (state_d != state_q);
    fifo_rd_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
    // Registered pulse must land on the last stop cycle, so look one count ahead.
    frame_done_d = (state_q == S_STOP) && (cnt == CNT_WIDTH'(CLKS_PER_BIT - 2));

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tx_q         <= 1'b1;
      fifo_rd_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tx_q         <= tx_d;
      fifo_rd_q    <= fifo_rd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign fifo_rd    = fifo_rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
